cube_point_launcher: RTL

- Front-panel controller that produces the start parameters and the launch reset for the jumping-point animation on the 8x8x8 RGB cube.
- Debounces the four push-buttons and lets the user edit the start X/Y/Z coordinates and colour.
- Launches the animation with an active-low reset pulse, and pauses or stops it on request.
- Sits between the board KEY/SW inputs and the jumping-point block's `resetn`/`pause`/`rcm`/`x`/`y`/`z`/`c` inputs.

---
 rtl/cube_point_launcher.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cube_point_launcher.sv
// cube_point_launcher
//   Front-panel controller for the jumping-point animation on the 8x8x8 RGB
//   cube. Debounces the four push-buttons, lets the user edit the start
//   X/Y/Z coordinates and colour, and launches the animation by pulsing its
//   active-low reset. Pauses or stops the animation on request.
//
// Optional feature macro: CUBE_EDIT_PREVIEW_EN
//   Defined   : in EDIT the cube shows a static point; every edit event
//               re-pulses launch_n for LAUNCH_CYC cycles so the animation
//               re-latches the new values.
//   Undefined : launch_n is held low throughout EDIT (cube blank).
//
// Ports
//   clk       in   system clock (50 MHz)
//   resetn    in   synchronous active-low reset
//   key_n     in   raw push-buttons, active-low, asynchronous
//                  [0] increment, [1] decrement, [2] next field, [3] launch/stop
//   sw_rcm    in   rainbow colour mode request
//   sw_pause  in   pause request while running
//   x,y,z,c   out  start coordinates and colour
//   field     out  field being edited: 0=x 1=y 2=z 3=c
//   rcm       out  registered sw_rcm
//   pause     out  pause to the animation
//   launch_n  out  active-low synchronous reset to the animation block
//   state     out  0=EDIT 1=LAUNCH 2=RUN
module cube_point_launcher #(
  parameter int DEBOUNCE   = 500000,
  parameter int LAUNCH_CYC = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       sw_rcm,
  input  logic       sw_pause,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [2:0] z,
  output logic [2:0] c,
  output logic [1:0] field,
  output logic       rcm,
  output logic       pause,
  output logic       launch_n,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int RW = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
  // Remaining low cycles after the first one of a launch_n pulse.
  localparam logic [RW-1:0] REM_INIT = RW'(LAUNCH_CYC - 1);

  // ---------------------------------------------------------------------
  // Key conditioning: 2-FF synchroniser, debounce counter, press pulse.
  // ---------------------------------------------------------------------
  logic [3:0]    sync1, sync2, stable, press;
  logic [CW-1:0] db_cnt [4];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      // NOTE: the debounce counters are a handful of flops, not a RAM, so
      // clearing them in reset is cheap and keeps the first press exact.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
            // Only a released->pressed change (stable was 1) is an event.
            press[i]  <= stable[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM: state register / next-state comb / output comb.
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [1:0]    field_q, field_d;
  logic          launch_n_d, pause_d;
`ifdef CUBE_EDIT_PREVIEW_EN
  logic          pulse_d;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_EDIT;
      rem_q    <= REM_INIT;
      field_q  <= 2'd0;
      launch_n <= 1'b0;
      pause    <= 1'b1;
      rcm      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      field_q  <= field_d;
      launch_n <= launch_n_d;
      pause    <= pause_d;
      rcm      <= sw_rcm;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    field_d = field_q;
`ifdef CUBE_EDIT_PREVIEW_EN
    pulse_d = 1'b0;
`endif
    case (state_q)
      ST_EDIT: begin
        if (press[3]) begin
          state_d = ST_LAUNCH;
          rem_d   = REM_INIT;
        end else begin
          if (press[2]) field_d = field_q + 2'd1;
`ifdef CUBE_EDIT_PREVIEW_EN
          // Any edit event (re)starts a preview pulse; otherwise finish
          // the one in progress.
          if (|press[2:0]) begin
            rem_d   = REM_INIT;
            pulse_d = 1'b1;
          end else if (rem_q != '0) begin
            rem_d   = rem_q - RW'(1);
            pulse_d = 1'b1;
          end
`endif
        end
      end
      ST_LAUNCH: begin
        if (rem_q == '0) state_d = ST_RUN;
        else             rem_d   = rem_q - RW'(1);
      end
      ST_RUN: begin
        if (press[3]) begin
          state_d = ST_EDIT;
          rem_d   = '0;
        end
      end
      default: begin
        state_d = ST_EDIT;
        rem_d   = '0;
      end
    endcase
  end

  // Outputs are a function of the next state and registered above.
  always_comb begin
    launch_n_d = 1'b1;
    pause_d    = 1'b1;
    case (state_d)
`ifdef CUBE_EDIT_PREVIEW_EN
      ST_EDIT:   launch_n_d = ~pulse_d;
`else
      ST_EDIT:   launch_n_d = 1'b0;
`endif
      ST_LAUNCH: launch_n_d = 1'b0;
      ST_RUN:    pause_d    = sw_pause;
      default:   launch_n_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Coordinate / colour registers, editable only in EDIT.
  // ---------------------------------------------------------------------
  logic [2:0] coord [4];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      coord <= '{3'd0, 3'd0, 3'd0, 3'd1};
    end else if (state_q == ST_EDIT && !press[3] && !press[2] &&
                 (press[0] ^ press[1])) begin
      coord[field_q] <= press[0] ? coord[field_q] + 3'd1
                                 : coord[field_q] - 3'd1;
    end
  end

  assign x     = coord[0];
  assign y     = coord[1];
  assign z     = coord[2];
  assign c     = coord[3];
  assign field = field_q;
  assign state = state_q;

endmodule
